conv2d_im2col_sched: RTL and testbench
======================================

Name: conv2d_im2col_sched

Overview:
Sequential im2col engine and scheduler feeding the systolic array. It walks the conv output grid, reads the image one element per cycle from the image buffer SRAM, and assembles each K×K patch with zero padding inserted. Each patch goes to the SA input stage over a valid/ready handshake. It replaces the flat combinational unroll for large images, where the full feature-map vector is too wide to build.

Parameters:
- BITWIDTH, 8, element width (signed).
- IMAGE_WIDTH, 28, image rows (index m).
- IMAGE_HEIGHT, 28, image columns (index n).
- WEIGHT_WIDTH, 3, kernel rows (index p).
- WEIGHT_HEIGHT, 3, kernel columns (index q).
- PADDING, 0, zero border on all sides.
- STRIDE, 1, window step in both dimensions.
- ADDR_WIDTH, 10, image buffer address width; must satisfy 2^ADDR_WIDTH >= IMAGE_WIDTH*IMAGE_HEIGHT.
- IDX_WIDTH, 10, patch index width; must satisfy 2^IDX_WIDTH >= OUT_ROWS*OUT_COLS.
- Derived localparams:
  - OUT_ROWS = (IMAGE_WIDTH + 2*PADDING - WEIGHT_WIDTH)/STRIDE + 1
  - OUT_COLS = (IMAGE_HEIGHT + 2*PADDING - WEIGHT_HEIGHT)/STRIDE + 1
  - KK = WEIGHT_WIDTH*WEIGHT_HEIGHT

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a full image pass.
- busy  out  1  high from FETCH entry until done.
- done  out  1  one-cycle pulse after the last patch handshake.
- mem_rd_en  out  1  image buffer read strobe.
- mem_rd_addr  out  ADDR_WIDTH  read address = m*IMAGE_HEIGHT + n (unpadded coordinates).
- mem_rd_data  in  BITWIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- patch_valid  out  1  patch_data is valid.
- patch_ready  in  1  SA input stage accepts the patch.
- patch_data  out  KK*BITWIDTH  element p*WEIGHT_HEIGHT+q sits at [KK*BITWIDTH-1 - (p*WEIGHT_HEIGHT+q)*BITWIDTH -: BITWIDTH] (MSB first).
- patch_idx  out  IDX_WIDTH  output position r*OUT_COLS + c.
- patch_last  out  1  high with the final patch (idx = OUT_ROWS*OUT_COLS-1).

Behaviour:
- Reset: state=IDLE. busy, done, mem_rd_en, patch_valid, patch_last = 0. mem_rd_addr, patch_data, patch_idx = 0. Reset takes effect in any state and aborts a pass; no done is issued for the aborted pass.
- FSM states: IDLE, FETCH, CAPT, OUT, DONE.
- IDLE: on start, set r=c=0, k=0, go to FETCH. start is ignored in every other state.
- FETCH, one cycle per k = 0..KK-1:
  - p = k / WEIGHT_HEIGHT, q = k % WEIGHT_HEIGHT.
  - Padded coordinates: pm = r*STRIDE + p, pn = c*STRIDE + q.
  - In-image (PADDING <= pm < IMAGE_WIDTH+PADDING and PADDING <= pn < IMAGE_HEIGHT+PADDING): mem_rd_en=1, addr=(pm-PADDING)*IMAGE_HEIGHT + (pn-PADDING).
  - Otherwise: mem_rd_en=0, and slot k is marked zero.
  - The slot for read k-1 is captured from mem_rd_data, or zero if marked.
  - After k=KK-1, go to CAPT.
- CAPT: capture slot KK-1; mem_rd_en=0; go to OUT.
- Latency: patch_valid rises KK+1 cycles after the first FETCH cycle (10 cycles for a 3×3 kernel).
- OUT: patch_valid=1.
  - patch_data, patch_idx and patch_last are held stable while patch_valid && !patch_ready.
  - On patch_valid && patch_ready: patch_valid drops next cycle.
  - If patch_last: go to DONE.
  - Otherwise advance c, wrapping to 0 and incrementing r at OUT_COLS; k=0; go to FETCH. No bubble cycle besides the state change.
- DONE: done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- No reads are issued while in OUT, so backpressure never drops SRAM data.
- Arithmetic: all indices are unsigned. Padding compares must be done on padded coordinates, so there is no negative wrap.
- Throughput: one patch per KK+2 cycles at full ready.

Test Plan:
1. 4×4 image, 3×3 kernel, P=0, S=1, mem returns data = addr. Start -> 4 patches. Patch0 = {0,1,2,4,5,6,8,9,10}. Patch3 = {5,6,7,9,10,11,13,14,15}, with patch_last=1. One done pulse follows.
2. Same image with P=1 -> 16 patches. Patch0 = {0,0,0,0,0,1,0,4,5}, and exactly 4 mem_rd_en pulses occur during its fetch. Patch15 = {10,11,0,14,15,0,0,0,0}.
3. 5×5 image, S=2, P=0 -> 2×2 output. Patch1 reads addresses 2,3,4,7,8,9,12,13,14. patch_idx values run 0,1,2,3.
4. Hold patch_ready low for 5 cycles in OUT -> patch_data and patch_idx are unchanged, mem_rd_en stays 0, and exactly one handshake is counted.
5. Assert rst during the FETCH of patch 2 -> the next cycle shows all outputs 0 and state IDLE. A new start then restarts at patch_idx 0.
6. Pulse start while busy -> no effect, and patch count is unchanged. Timing check: patch_valid goes high exactly 10 cycles after the first mem_rd_en of each patch.

Source files
------------

// File: rtl/conv2d_im2col_sched.sv
// Sequential im2col engine: walks the conv output grid, fetches one image element per
// cycle from the image buffer and hands zero-padded KxK patches to the systolic array.
module conv2d_im2col_sched #(
  parameter int unsigned BITWIDTH      = 8,
  parameter int unsigned IMAGE_WIDTH   = 28,
  parameter int unsigned IMAGE_HEIGHT  = 28,
  parameter int unsigned WEIGHT_WIDTH  = 3,
  parameter int unsigned WEIGHT_HEIGHT = 3,
  parameter int unsigned PADDING       = 0,
  parameter int unsigned STRIDE        = 1,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned IDX_WIDTH     = 10
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                           mem_rd_addr,
  input  logic [BITWIDTH-1:0]                             mem_rd_data,
  output logic                                            patch_valid,
  input  logic                                            patch_ready,
  output logic [WEIGHT_WIDTH*WEIGHT_HEIGHT*BITWIDTH-1:0]  patch_data,
  output logic [IDX_WIDTH-1:0]                            patch_idx,
  output logic                                            patch_last
);

  localparam int unsigned KK       = WEIGHT_WIDTH * WEIGHT_HEIGHT;
  localparam int unsigned OUT_ROWS = (IMAGE_WIDTH + 2 * PADDING - WEIGHT_WIDTH) / STRIDE + 1;
  localparam int unsigned OUT_COLS = (IMAGE_HEIGHT + 2 * PADDING - WEIGHT_HEIGHT) / STRIDE + 1;
  localparam int unsigned TOTAL    = OUT_ROWS * OUT_COLS;
  localparam int unsigned K_W      = $clog2(KK + 1);
  localparam int unsigned RC_W     = 16;

  typedef enum logic [2:0] {IDLE, FETCH, CAPT, OUT, DONE} state_t;

  state_t                state, state_n;
  logic [K_W-1:0]        k, k_n;
  logic [RC_W-1:0]       r, r_n, c, c_n;
  logic [IDX_WIDTH-1:0]  idx_n;
  logic                  rd_en_d;
  logic                  busy_n, done_n, valid_n, last_n, rd_en_n;
  logic [ADDR_WIDTH-1:0] rd_addr_n;
  logic                  cap_en;
  logic [K_W-1:0]        cap_slot;
  logic [BITWIDTH-1:0]   cap_val;
  logic [31:0]           p, q, pm, pn;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, walk counters, and next values of the registered outputs
  always_comb begin
    state_n   = state;
    k_n       = k;
    r_n       = r;
    c_n       = c;
    idx_n     = patch_idx;
    rd_addr_n = mem_rd_addr;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          k_n     = '0;
          r_n     = '0;
          c_n     = '0;
          idx_n   = '0;
        end
      end
      FETCH: begin
        if (k == K_W'(KK - 1)) state_n = CAPT;
        else                   k_n     = k + K_W'(1);
      end
      CAPT: state_n = OUT;
      OUT: begin
        if (patch_valid && patch_ready) begin
          if (patch_last) begin
            state_n = DONE;
          end else begin
            state_n = FETCH;
            k_n     = '0;
            idx_n   = patch_idx + IDX_WIDTH'(1);
            if (c == RC_W'(OUT_COLS - 1)) begin
              c_n = '0;
              r_n = r + RC_W'(1);
            end else begin
              c_n = c + RC_W'(1);
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Read issued in the cycle the FSM sits in FETCH with k_n; compares stay on padded coords
    p       = 32'(k_n) / WEIGHT_HEIGHT;
    q       = 32'(k_n) % WEIGHT_HEIGHT;
    pm      = 32'(r_n) * STRIDE + p;
    pn      = 32'(c_n) * STRIDE + q;
    rd_en_n = (state_n == FETCH) &&
              (pm >= PADDING) && (pm < IMAGE_WIDTH + PADDING) &&
              (pn >= PADDING) && (pn < IMAGE_HEIGHT + PADDING);
    if (rd_en_n) rd_addr_n = ADDR_WIDTH'((pm - PADDING) * IMAGE_HEIGHT + (pn - PADDING));

    busy_n  = (state_n == FETCH) || (state_n == CAPT) || (state_n == OUT);
    done_n  = (state_n == DONE);
    valid_n = (state_n == OUT);
    last_n  = (state_n == OUT) && (idx_n == IDX_WIDTH'(TOTAL - 1));

    // Slot k-1 lands one cycle after its read; skipped reads become zero
    cap_en   = ((state == FETCH) && (k != '0)) || (state == CAPT);
    cap_slot = (state == CAPT) ? K_W'(KK - 1) : (k - K_W'(1));
    cap_val  = rd_en_d ? mem_rd_data : '0;
  end

  // Counters, registered outputs and patch assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      k           <= '0;
      r           <= '0;
      c           <= '0;
      patch_idx   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      rd_en_d     <= 1'b0;
      patch_valid <= 1'b0;
      patch_last  <= 1'b0;
      patch_data  <= '0;
    end else begin
      k           <= k_n;
      r           <= r_n;
      c           <= c_n;
      patch_idx   <= idx_n;
      busy        <= busy_n;
      done        <= done_n;
      mem_rd_en   <= rd_en_n;
      mem_rd_addr <= rd_addr_n;
      rd_en_d     <= mem_rd_en;
      patch_valid <= valid_n;
      patch_last  <= last_n;
      for (int s = 0; s < KK; s++) begin
        if (cap_en && (cap_slot == K_W'(s)))
          patch_data[KK*BITWIDTH-1 - s*BITWIDTH -: BITWIDTH] <= cap_val;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_im2col_sched.sv
// Randomized scoreboard bench for conv2d_im2col_sched: non-square image and kernel with
// padding and stride, random backpressure, start-while-busy and mid-pass reset.
module tb_conv2d_im2col_sched;

  localparam int unsigned BW    = 8;
  localparam int unsigned IW    = 5;
  localparam int unsigned IH    = 6;
  localparam int unsigned WW    = 3;
  localparam int unsigned WH    = 2;
  localparam int unsigned P     = 1;
  localparam int unsigned S     = 2;
  localparam int unsigned AW    = 10;
  localparam int unsigned IXW   = 10;
  localparam int unsigned KK    = WW * WH;
  localparam int unsigned PW    = KK * BW;
  localparam int unsigned OR    = (IW + 2 * P - WW) / S + 1;
  localparam int unsigned OC    = (IH + 2 * P - WH) / S + 1;
  localparam int unsigned TOTAL = OR * OC;
  localparam int unsigned NPIX  = IW * IH;

  typedef struct {
    logic [PW-1:0] data;
    int unsigned   idx;
    logic          last;
  } patch_t;

  logic           clk = 1'b0;
  logic           rst, start, busy, done, mem_rd_en, patch_valid, patch_ready, patch_last;
  logic [AW-1:0]  mem_rd_addr;
  logic [BW-1:0]  mem_rd_data;
  logic [PW-1:0]  patch_data;
  logic [IXW-1:0] patch_idx;

  conv2d_im2col_sched #(
    .BITWIDTH(BW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .WEIGHT_WIDTH(WW),
    .WEIGHT_HEIGHT(WH), .PADDING(P), .STRIDE(S), .ADDR_WIDTH(AW), .IDX_WIDTH(IXW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .patch_valid(patch_valid), .patch_ready(patch_ready), .patch_data(patch_data),
    .patch_idx(patch_idx), .patch_last(patch_last)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] img [NPIX];
  patch_t        exp_q [$];
  int unsigned   rd_q [$];
  int            n_checks = 0, n_fail = 0;
  int            cyc = 0, hs_count = 0, done_count = 0, last_hs = 0, exp_rise = -1;
  int            ready_mode = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: every patch and every in-image read address of one pass, in order
  task automatic load_pass();
    for (int i = 0; i < NPIX; i++) img[i] = BW'($urandom);
    for (int r = 0; r < OR; r++) begin
      for (int c = 0; c < OC; c++) begin
        patch_t e;
        e.data = '0;
        for (int pp = 0; pp < WW; pp++) begin
          for (int qq = 0; qq < WH; qq++) begin
            int unsigned   pm, pn, a;
            logic [BW-1:0] v;
            pm = r * S + pp;
            pn = c * S + qq;
            v  = '0;
            if (pm >= P && pm < IW + P && pn >= P && pn < IH + P) begin
              a = (pm - P) * IH + (pn - P);
              v = img[a];
              rd_q.push_back(a);
            end
            e.data = (e.data << BW) | PW'(v);
          end
        end
        e.idx  = r * OC + c;
        e.last = (e.idx == TOTAL - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Image buffer with one-cycle read latency, plus backpressure generator
  initial begin : drivers
    logic          en_s;
    logic [AW-1:0] addr_s;
    int            hold_cnt;
    hold_cnt    = 0;
    mem_rd_data = '0;
    patch_ready = 1'b0;
    forever begin
      @(negedge clk);
      en_s   = mem_rd_en;
      addr_s = mem_rd_addr;
      @(posedge clk);
      #1;
      mem_rd_data = (en_s && addr_s < AW'(NPIX)) ? img[addr_s] : BW'($urandom);
      hold_cnt++;
      case (ready_mode)
        0:       patch_ready = 1'b1;
        1:       patch_ready = ($urandom_range(0, 99) < 40);
        default: patch_ready = ((hold_cnt % 6) == 5);
      endcase
    end
  end

  // Monitor: reads, patch handshakes, hold stability, latency and done pulse
  logic          prev_valid, prev_ready, prev_busy, prev_last;
  logic [PW-1:0] prev_data;
  logic [IXW-1:0] prev_idx;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_busy  = 1'b0;
      exp_rise   = -1;
    end else begin
      if (mem_rd_en) begin
        check("rd_while_valid", patch_valid, 0);
        check("rd_while_busy", busy, 1);
        if (rd_q.size() == 0) fail_now("rd_unexpected");
        else check("rd_addr", mem_rd_addr, rd_q.pop_front());
      end
      if (busy && !prev_busy) exp_rise = cyc + KK + 1;
      if (patch_valid && !prev_valid) check("valid_latency", cyc, exp_rise);
      if (patch_valid && prev_valid && !prev_ready) begin
        check("hold_data", patch_data, prev_data);
        check("hold_idx", patch_idx, prev_idx);
        check("hold_last", patch_last, prev_last);
      end
      if (patch_valid && patch_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("patch_unexpected");
        end else begin
          patch_t e;
          e = exp_q.pop_front();
          check("patch_data", patch_data, e.data);
          check("patch_idx", patch_idx, e.idx);
          check("patch_last", patch_last, e.last);
        end
        hs_count++;
        last_hs  = cyc;
        exp_rise = cyc + KK + 2;
      end
      if (done) begin
        done_count++;
        check("done_timing", cyc, last_hs + 1);
        check("done_busy", busy, 0);
      end
      prev_valid = patch_valid;
      prev_ready = patch_ready;
      prev_busy  = busy;
      prev_data  = patch_data;
      prev_idx   = patch_idx;
      prev_last  = patch_last;
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_valid", patch_valid, 0);
    check("rst_data", patch_data, 0);
    check("rst_idx", patch_idx, 0);
    check("rst_last", patch_last, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0, i;
    d0 = done_count;
    i  = 0;
    while (done_count == d0 && i < 4000) begin
      @(posedge clk);
      i++;
    end
    if (done_count == d0) fail_now(name);
    @(negedge clk);
  endtask

  task automatic end_of_pass_checks(input int exp_dones);
    check("pass_handshakes", hs_count, TOTAL);
    check("pass_patches_left", exp_q.size(), 0);
    check("pass_reads_left", rd_q.size(), 0);
    check("pass_done_count", done_count, exp_dones);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_pass(input int mode, input int exp_dones);
    ready_mode = mode;
    hs_count   = 0;
    load_pass();
    pulse_start();
    wait_done("done_timeout");
    end_of_pass_checks(exp_dones);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int i;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;

    // Full-rate pass with a stray start while busy
    ready_mode = 0;
    hs_count   = 0;
    load_pass();
    pulse_start();
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("busy_before_stray_start", busy, 1);
    pulse_start();
    wait_done("done_timeout_stray");
    end_of_pass_checks(1);
    repeat (3) @(posedge clk);

    run_pass(1, 2);
    run_pass(2, 3);

    // Reset in the middle of fetching patch 2 aborts the pass without a done
    ready_mode = 0;
    hs_count   = 0;
    load_pass();
    pulse_start();
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(mem_rd_en && patch_idx == IXW'(2) && !patch_valid) && i < 500);
    if (i >= 500) fail_now("abort_point_timeout");
    @(posedge clk);
    #1 begin
      rst = 1'b1;
      exp_q.delete();
      rd_q.delete();
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("abort_no_done", done_count, 3);
    check("abort_idle_busy", busy, 0);

    run_pass(0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
